mio_bus_arbiter: RTL and testbench
==================================

// Module: mio_bus_arbiter
// PURPOSE
//  Shares the single memory/IO bus among NUM_REQ masters: req 0 = CPU control FSM, others = DMA/VGA etc.
//  Issues one transaction at a time on the bus and returns a per-master ready pulse (the CPU's MIO_ready).
//  Round-robin grant order; bus timeout produces an error completion instead of a hang.
// PARAMETERS
//  NUM_REQ   3    number of masters (2..8); index 0 is the CPU
//  DATA_W    32   bus data width
//  ADDR_W    32   bus address width
//  TIMEOUT   255  max cycles waiting for mem_ack before abort (1..65535)
// PORTS
//  clk        in   1               clock
//  reset      in   1               asynchronous, active-high
//  req_rd     in   NUM_REQ         per-master read request, held until that master's req_ready
//  req_wr     in   NUM_REQ         per-master write request, held until req_ready
//  req_addr   in   NUM_REQ*ADDR_W  packed addresses; master i = [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W  packed write data
//  req_ready  out  NUM_REQ         one-cycle completion pulse to the granted master
//  req_rdata  out  DATA_W          read data, valid in the req_ready cycle
//  bus_err    out  1               pulses with req_ready on timeout or rd&wr conflict
//  grant_id   out  3               index of the current or last granted master
//  mem_rd     out  1               bus read strobe
//  mem_wr     out  1               bus write strobe
//  mem_addr   out  ADDR_W          bus address
//  mem_wdata  out  DATA_W          bus write data
//  mem_rdata  in   DATA_W          bus read data, valid with mem_ack
//  mem_ack    in   1               bus completion, sampled while in WAIT
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, rr pointer 0 (master 0 highest priority first), timeout count 0.
//  Reset mid-transaction: strobes drop immediately and no ready is issued; masters re-request.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs registered.
//   IDLE:  pending = req_rd|req_wr. If none, stay.
//          Else grant the first pending master at or after ptr, cyclically; latch id, addr, wdata, rd/wr.
//          If that master has rd&wr both set: go to DONE with error=1 and no bus cycle.
//   ISSUE: drive mem_rd or mem_wr with addr/wdata; go to WAIT; clear the timeout counter.
//   WAIT:  hold the strobes. mem_ack=1: capture mem_rdata (reads only) and go to DONE.
//          Else, once count==TIMEOUT: drop the strobes, rdata=0, error=1, go to DONE.
//   DONE:  req_ready[id]=1 for exactly one cycle, bus_err=error, strobes low.
//          ptr <= id+1 (wrap to 0 at NUM_REQ). Go to IDLE.
//  Latency: request sampled at edge k -> strobe visible after edge k+1.
//   mem_ack sampled at edge m -> req_ready high after edge m+1.
//   Minimum turnaround 4 cycles per transaction; mem_ack in the first WAIT cycle is legal.
//  Master deasserts mid-transaction: the bus cycle completes anyway and the ready pulse is still issued.
//  A master must not re-sample ready as a new grant; the next grant needs IDLE again.
//  mem_ack outside WAIT is ignored. Write completions return req_rdata = 0.
//  Fairness: a master continuously requesting waits at most NUM_REQ-1 other transactions.
//  grant_id holds its last value in IDLE.
// STRUCTURE
//  Package mio_arb_pkg: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3),
//   REQ_CPU=0, max NUM_REQ constant.
//  Sub-module rr_picker (combinational): inputs pending vector and ptr; outputs valid and index.
//  The FSM, latches and timeout counter stay in this module.
// TESTING
//  1 CPU read only, addr 0x100, mem_ack on the 2nd WAIT cycle with data 0xDEADBEEF
//    -> mem_rd high 2 cycles, req_ready[0] pulse, rdata=0xDEADBEEF, bus_err=0.
//  2 Masters 0,1,2 request continuously, ack immediate -> grant order 0,1,2,0,1,2; each waits <=2 transactions.
//  3 Master 1 write 0x55AA to 0x2000, mem_ack never comes, TIMEOUT=8
//    -> strobe dropped after 8 WAIT cycles, req_ready[1] and bus_err pulse, rdata=0.
//  4 Master 2 asserts rd&wr together -> no mem strobe, req_ready[2] and bus_err in the same cycle, ptr -> 0.
//  5 Reset asserted during WAIT of a CPU read -> mem_rd=0 asynchronously, no req_ready;
//    after release CPU re-request is served normally.
//  6 Master 1 drops req_wr during WAIT, then ack -> req_ready[1] still pulses, next grant starts in IDLE.

Source files
------------

// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the memory/IO bus arbiter: FSM state encoding,
// master index constants and the round-robin pointer advance helper.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int REQ_CPU     = 0;
    localparam int MAX_NUM_REQ = 8;

    // Next round-robin start position: the master after id, wrapping to the CPU.
    function automatic logic [2:0] next_ptr(input logic [2:0] id, input int num_req);
        if (int'(id) >= num_req - 1) begin
            return 3'(REQ_CPU);
        end
        return id + 3'd1;
    endfunction

endpackage

// File: rtl/mio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first pending master at or
// after the pointer, searching cyclically.
module rr_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [2:0]         i_ptr,
    output logic               o_valid,
    output logic [2:0]         o_index
);

    int w_rel;
    int w_best;

    // Distance from the pointer decides priority; the smallest pending distance wins.
    always_comb begin
        o_valid = 1'b0;
        o_index = 3'd0;
        w_rel   = 0;
        w_best  = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= int'(i_ptr)) begin
                w_rel = i - int'(i_ptr);
            end else begin
                w_rel = i - int'(i_ptr) + NUM_REQ;
            end
            if (i_pending[i] && (w_rel < w_best)) begin
                w_best  = w_rel;
                o_valid = 1'b1;
                o_index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter sharing one memory/IO bus among NUM_REQ masters, one
// transaction at a time, with a timeout that turns a missing ack into an error completion.
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        i_req_rd,
    input  logic [NUM_REQ-1:0]        i_req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [DATA_W-1:0]         o_req_rdata,
    output logic                      o_bus_err,
    output logic [2:0]                o_grant_id,
    output logic                      o_mem_rd,
    output logic                      o_mem_wr,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata,
    input  logic                      i_mem_ack
);

    // The abort fires on the TIMEOUT-th WAIT cycle without an ack.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    arb_state_t          r_state;
    logic [2:0]          r_ptr;
    logic [2:0]          r_id;
    logic                r_rd;
    logic                r_wr;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_capt;
    logic [15:0]         r_count;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [DATA_W-1:0]   r_req_rdata;
    logic                r_bus_err;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [NUM_REQ-1:0]  w_pending;
    logic                w_pick_valid;
    logic [2:0]          w_pick_id;
    logic                w_sel_rd;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [NUM_REQ-1:0]  w_ready_vec;

    assign w_pending = i_req_rd | i_req_wr;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_pending (w_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_pick_valid),
        .o_index   (w_pick_id)
    );

    always_comb begin
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_id == 3'(i)) begin
                w_sel_rd    = i_req_rd[i];
                w_sel_wr    = i_req_wr[i];
                w_sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = i_req_wdata[i*DATA_W +: DATA_W];
            end
            w_ready_vec[i] = (r_id == 3'(i));
        end
    end

    // Completion outputs are pulsed only from DONE; every other state clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'(REQ_CPU);
            r_id        <= 3'd0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_capt      <= '0;
            r_count     <= 16'd0;
            r_req_ready <= '0;
            r_req_rdata <= '0;
            r_bus_err   <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_req_ready <= '0;
            r_req_rdata <= '0;
            r_bus_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_id    <= w_pick_id;
                        r_rd    <= w_sel_rd;
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_capt  <= '0;
                        if (w_sel_rd && w_sel_wr) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_mem_rd    <= r_rd;
                    r_mem_wr    <= r_wr;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= r_wdata;
                    r_count     <= 16'd0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mem_ack) begin
                        r_capt   <= r_rd ? i_mem_rdata : '0;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if (r_count == TIMEOUT_LAST) begin
                        r_capt   <= '0;
                        r_err    <= 1'b1;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_req_ready <= w_ready_vec;
                    r_req_rdata <= r_capt;
                    r_bus_err   <= r_err;
                    r_ptr       <= next_ptr(r_id, NUM_REQ);
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_req_rdata = r_req_rdata;
    assign o_bus_err   = r_bus_err;
    assign o_grant_id  = r_id;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: table-driven single transactions plus hand-written
// reset-in-WAIT and round-robin sequences, with a completion scoreboard.
module tb_mio_bus_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    i_req_rd = '0;
    logic [NR-1:0]    i_req_wr = '0;
    logic [NR*AW-1:0] i_req_addr = '0;
    logic [NR*DW-1:0] i_req_wdata = '0;
    logic [NR-1:0]    o_req_ready;
    logic [DW-1:0]    o_req_rdata;
    logic             o_bus_err;
    logic [2:0]       o_grant_id;
    logic             o_mem_rd;
    logic             o_mem_wr;
    logic [AW-1:0]    o_mem_addr;
    logic [DW-1:0]    o_mem_wdata;
    logic [DW-1:0]    i_mem_rdata = '0;
    logic             i_mem_ack = 1'b0;

    typedef struct {
        int          master;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackCycle;
        logic [31:0] memData;
        int          dropAt;
        logic [31:0] expRdata;
        bit          expErr;
        int          expLat;
        int          expStrobe;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    int          modelPtr = 0;

    int          ackCycle = 0;
    int          strobeCyc = 0;
    int          strobeTotal = 0;
    bit          busBad = 1'b0;
    bit          busChk = 1'b1;
    bit          useAddrData = 1'b0;
    bit          expRd = 1'b0;
    bit          expWr = 1'b0;
    logic [31:0] expAddr = '0;
    logic [31:0] expWdata = '0;
    logic [31:0] memData = '0;

    mio_bus_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_req_rd    (i_req_rd),
        .i_req_wr    (i_req_wr),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_req_ready (o_req_ready),
        .o_req_rdata (o_req_rdata),
        .o_bus_err   (o_bus_err),
        .o_grant_id  (o_grant_id),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack)
    );

    always #5 clk = ~clk;

    // Memory model: acks on the programmed strobe cycle and checks the bus contents.
    always @(negedge clk) begin
        if (o_mem_rd || o_mem_wr) begin
            strobeCyc++;
            strobeTotal++;
            if (busChk && (o_mem_rd !== expRd || o_mem_wr !== expWr || o_mem_addr !== expAddr ||
                           (expWr && o_mem_wdata !== expWdata))) begin
                busBad = 1'b1;
            end
            i_mem_ack = (ackCycle != 0) && (strobeCyc == ackCycle);
            if (i_mem_ack) begin
                i_mem_rdata = useAddrData ? (o_mem_addr ^ 32'hC0DE_0000) : memData;
            end else begin
                i_mem_rdata = 32'hBAD0_BAD0;
            end
        end else begin
            strobeCyc   = 0;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'hBAD0_BAD0;
        end
    end

    // Completion monitor: every ready pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t          e;
        logic [NR-1:0] oh;
        if (!reset) begin
            if (o_bus_err && o_req_ready == '0) begin
                total++;
                bad++;
                $display("[TB] FAIL err_without_ready: bus_err=1 ready=%b required ready pulse", o_req_ready);
            end
            if (o_req_ready != '0) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_ready: ready=%b required none", o_req_ready);
                end else begin
                    e  = sbq.pop_front();
                    oh = NR'(1) << e.id;
                    if (o_req_ready !== oh || o_req_rdata !== e.rdata || o_bus_err !== e.err ||
                        o_grant_id !== 3'(e.id)) begin
                        bad++;
                        $display("[TB] FAIL completion: ready=%b rdata=0x%0h err=%0b gid=%0d required ready=%b rdata=0x%0h err=%0b gid=%0d",
                                 o_req_ready, o_req_rdata, o_bus_err, o_grant_id, oh, e.rdata, e.err, e.id);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int            lat;
        exp_t          e;
        logic [NR-1:0] mask;
        expRd       = v.rd;
        expWr       = v.wr;
        expAddr     = v.addr;
        expWdata    = v.wdata;
        ackCycle    = v.ackCycle;
        memData     = v.memData;
        strobeTotal = 0;
        busBad      = 1'b0;
        mask        = NR'(1) << v.master;
        i_req_addr  = (NR*AW)'(v.addr) << (v.master * AW);
        i_req_wdata = (NR*DW)'(v.wdata) << (v.master * DW);
        i_req_rd    = v.rd ? mask : '0;
        i_req_wr    = v.wr ? mask : '0;
        e.id    = v.master;
        e.rdata = v.expRdata;
        e.err   = v.expErr;
        sbq.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (v.dropAt != 0 && lat == v.dropAt) begin
                i_req_rd = '0;
                i_req_wr = '0;
            end
        end while (o_req_ready == '0 && lat < 60);
        i_req_rd = '0;
        i_req_wr = '0;
        checkOutput($sformatf("row%0d_latency", idx), 32'(lat), 32'(v.expLat));
        repeat (3) @(negedge clk);
        checkOutput($sformatf("row%0d_strobe_cycles", idx), 32'(strobeTotal), 32'(v.expStrobe));
        checkOutput($sformatf("row%0d_bus_contents", idx), 32'(busBad), 32'd0);
        modelPtr = (v.master + 1) % NR;
    endtask

    initial begin
        int          lat;
        int          seen;
        int          p;
        exp_t        e;
        logic [31:0] rrAddr [NR];

        // master rd wr addr wdata ack memData drop | expRdata err lat strobes
        vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        2, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 5, 2};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_2000, 32'h0000_55AA, 0, 32'h1111_1111, 0, 32'h0,        1'b1, 11, 8};
        vecs[2] = '{2, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_00AB, 1, 32'h2222_2222, 0, 32'h0,        1'b1, 2, 0};
        vecs[3] = '{1, 1'b1, 1'b0, 32'h0000_0044, 32'h0,        1, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 4, 1};
        vecs[4] = '{2, 1'b0, 1'b1, 32'h0000_0048, 32'h0000_CAFE, 3, 32'h3333_3333, 0, 32'h0,        1'b0, 6, 3};
        vecs[5] = '{1, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_1234, 3, 32'h4444_4444, 3, 32'h0,        1'b0, 6, 3};
        vecs[6] = '{0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,        1, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5, 1'b0, 4, 1};
        vecs[7] = '{0, 1'b1, 1'b0, 32'h0000_0084, 32'h0,        8, 32'h7777_7777, 0, 32'h7777_7777, 1'b0, 11, 8};

        repeat (2) @(negedge clk);
        checkOutput("reset_ready",   32'(o_req_ready), 32'd0);
        checkOutput("reset_rdata",   o_req_rdata,      32'd0);
        checkOutput("reset_bus_err", 32'(o_bus_err),   32'd0);
        checkOutput("reset_grant",   32'(o_grant_id),  32'd0);
        checkOutput("reset_mem_rd",  32'(o_mem_rd),    32'd0);
        checkOutput("reset_mem_wr",  32'(o_mem_wr),    32'd0);
        checkOutput("reset_mem_addr", o_mem_addr,      32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset lands in WAIT of a CPU read: strobe must drop at once, then a normal re-serve.
        expRd = 1'b1; expWr = 1'b0; expAddr = 32'h300; ackCycle = 0;
        memData = 32'h600D_F00D; busBad = 1'b0; strobeTotal = 0;
        i_req_addr = (NR*AW)'(32'h300);
        i_req_rd   = 3'b001;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_mem_rd && lat < 20);
        checkOutput("rst_strobe_seen", 32'(o_mem_rd), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_async_mem_rd", 32'(o_mem_rd),    32'd0);
        checkOutput("rst_async_ready",  32'(o_req_ready), 32'd0);
        checkOutput("rst_async_grant",  32'(o_grant_id),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelPtr = 0;
        ackCycle = 1;
        strobeTotal = 0;
        e.id = 0; e.rdata = 32'h600D_F00D; e.err = 1'b0;
        sbq.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (o_req_ready == '0 && lat < 40);
        i_req_rd = '0;
        checkOutput("rst_reserve_latency", 32'(lat), 32'd4);
        repeat (3) @(negedge clk);
        checkOutput("rst_reserve_strobes", 32'(strobeTotal), 32'd1);
        checkOutput("rst_reserve_bus",     32'(busBad),      32'd0);
        modelPtr = 1;

        // All three masters read continuously with immediate ack: strict rotation from the pointer.
        useAddrData = 1'b1; busChk = 1'b0; ackCycle = 1;
        for (int i = 0; i < NR; i++) begin
            rrAddr[i] = 32'h1000 + 32'(i) * 32'h10;
        end
        i_req_addr = {rrAddr[2], rrAddr[1], rrAddr[0]};
        i_req_rd   = 3'b111;
        p = modelPtr;
        for (int t = 0; t < 6; t++) begin
            e.id = p; e.rdata = rrAddr[p] ^ 32'hC0DE_0000; e.err = 1'b0;
            sbq.push_back(e);
            p = (p + 1) % NR;
        end
        seen = 0;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (o_req_ready != '0) seen++;
        end while (seen < 6 && lat < 200);
        i_req_rd = '0;
        modelPtr = p;
        checkOutput("rr_completions", 32'(seen), 32'd6);
        checkOutput("rr_cycles",      32'(lat),  32'd24);
        repeat (4) @(negedge clk);

        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
